// File: rtl/battleship_pkg.sv
// Shared battleship types and constants: placement FSM states, fleet shape
// and the bit layout of the accelerator update_ship word.
package battleship_pkg;

  localparam int NUM_SHIPS = 5;
  localparam int BOARD_DIM = 10;

  // Ship lengths indexed by ship number (element 0 is ship 0).
  localparam logic [NUM_SHIPS-1:0][3:0] SHIP_LEN = {4'd2, 4'd3, 4'd3, 4'd4, 4'd5};

  localparam int SLOT_A_POS_LSB  = 25;
  localparam int SLOT_A_VERT_BIT = 24;
  localparam int SLOT_A_TYPE_LSB = 21;
  localparam int SLOT_B_POS_LSB  = 14;
  localparam int SLOT_B_VERT_BIT = 13;
  localparam int SLOT_B_TYPE_LSB = 10;

  localparam logic [2:0] IGNORE_TYPE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_LOAD0,
    ST_LOAD1,
    ST_LOAD2,
    ST_CHECK,
    ST_EVAL,
    ST_DONE
  } place_state_t;

  function automatic logic [31:0] pack_update_word(
    input logic [6:0] pos_a,
    input logic       vert_a,
    input logic [2:0] type_a,
    input logic [6:0] pos_b,
    input logic       vert_b,
    input logic [2:0] type_b
  );
    logic [31:0] w;
    w = '0;
    w[SLOT_A_POS_LSB +: 7]  = pos_a;
    w[SLOT_A_VERT_BIT]      = vert_a;
    w[SLOT_A_TYPE_LSB +: 3] = type_a;
    w[SLOT_B_POS_LSB +: 7]  = pos_b;
    w[SLOT_B_VERT_BIT]      = vert_b;
    w[SLOT_B_TYPE_LSB +: 3] = type_b;
    return w;
  endfunction

endpackage

// File: rtl/placement_scheduler_if.sv
// CPU-side control/status and accelerator bus of the placement scheduler.
// master = the scheduler, slave = CPU register file plus accelerator.
interface placement_scheduler_if;
  logic        req;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic        success;
  logic [7:0]  tries;
  logic [34:0] ship_pos;
  logic [4:0]  ship_vert;
  logic [31:0] acc_data;
  logic        acc_update_ship;
  logic        acc_start;
  logic        acc_valid;

  modport master (
    input  req, seed, acc_valid,
    output busy, done, success, tries, ship_pos, ship_vert,
           acc_data, acc_update_ship, acc_start
  );

  modport slave (
    output req, seed, acc_valid,
    input  busy, done, success, tries, ship_pos, ship_vert,
           acc_data, acc_update_ship, acc_start
  );
endinterface

// File: rtl/placement_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left.
// Load has priority over enable.
module lfsr16 #(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RESET_VAL;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_en) begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/placement_scheduler.sv
// Draws a random five-ship fleet, loads it into the placement accelerator and
// redraws until it is legal. Optional retry cap: PLACEMENT_RETRY_LIMIT_EN.
module placement_scheduler
  import battleship_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          MAX_TRIES     = 64,
  parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst_n,
  placement_scheduler_if.master bus
);

  localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  place_state_t              r_state;
  place_state_t              w_next_state;
  logic [15:0]               w_lfsr;
  logic [15:0]               w_seed_val;
  logic                      w_lfsr_en;
  logic                      w_lfsr_load;
  logic [2:0]                r_idx;
  logic [NUM_SHIPS-1:0][6:0] r_pos;
  logic [NUM_SHIPS-1:0]      r_vert;
  logic [7:0]                r_tries;
  logic [7:0]                w_tries_inc;
  logic                      r_success;
  logic                      r_acc_valid;
  logic [SW-1:0]             r_settle_cnt;
  logic [3:0]                w_row;
  logic [3:0]                w_col;
  logic [3:0]                w_len;
  logic                      w_cand_vert;
  logic                      w_fits;
  logic                      w_last_ship;
  logic                      w_settle_last;
  logic                      w_limit_hit;
  logic [6:0]                w_pos;

  assign w_seed_val  = (bus.seed == 16'h0000) ? DEFAULT_SEED : bus.seed;
  assign w_lfsr_load = (r_state == ST_IDLE) && bus.req;
  assign w_lfsr_en   = (r_state == ST_DRAW);

  lfsr16 #(
    .RESET_VAL (DEFAULT_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_lfsr_en),
    .i_load     (w_lfsr_load),
    .i_load_val (w_seed_val),
    .o_state    (w_lfsr)
  );

  assign w_row       = w_lfsr[3:0];
  assign w_col       = w_lfsr[7:4];
  assign w_cand_vert = w_lfsr[8];
  assign w_len       = SHIP_LEN[r_idx];

  // A ship must start on the board and its far end must stay on the board.
  assign w_fits = (w_row < 4'(BOARD_DIM)) && (w_col < 4'(BOARD_DIM)) &&
                  (w_cand_vert ? ({1'b0, w_row} + {1'b0, w_len} <= 5'(BOARD_DIM))
                               : ({1'b0, w_col} + {1'b0, w_len} <= 5'(BOARD_DIM)));

  assign w_pos         = 7'(w_row) * 7'(BOARD_DIM) + 7'(w_col);
  assign w_last_ship   = (r_idx == 3'(NUM_SHIPS - 1));
  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_tries_inc   = (r_tries == 8'hFF) ? r_tries : r_tries + 8'd1;

`ifdef PLACEMENT_RETRY_LIMIT_EN
  assign w_limit_hit = (int'(w_tries_inc) >= MAX_TRIES);
`else
  logic w_unused_max_tries;
  assign w_limit_hit        = 1'b0;
  assign w_unused_max_tries = (MAX_TRIES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req) w_next_state = ST_DRAW;
      ST_DRAW:  if (w_fits && w_last_ship) w_next_state = ST_LOAD0;
      ST_LOAD0: w_next_state = ST_LOAD1;
      ST_LOAD1: w_next_state = ST_LOAD2;
      ST_LOAD2: w_next_state = ST_CHECK;
      ST_CHECK: if (w_settle_last) w_next_state = ST_EVAL;
      ST_EVAL: begin
        if (r_acc_valid || w_limit_hit) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_DRAW;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy            = (r_state != ST_IDLE);
    bus.done            = 1'b0;
    bus.acc_update_ship = 1'b0;
    bus.acc_start       = 1'b0;
    bus.acc_data        = '0;
    case (r_state)
      ST_LOAD0: begin
        bus.acc_update_ship = 1'b1;
        bus.acc_data = pack_update_word(r_pos[0], r_vert[0], 3'd0, r_pos[1], r_vert[1], 3'd1);
      end
      ST_LOAD1: begin
        bus.acc_update_ship = 1'b1;
        bus.acc_data = pack_update_word(r_pos[2], r_vert[2], 3'd2, r_pos[3], r_vert[3], 3'd3);
      end
      ST_LOAD2: begin
        bus.acc_update_ship = 1'b1;
        bus.acc_data = pack_update_word(r_pos[4], r_vert[4], 3'd4, 7'd0, 1'b0, IGNORE_TYPE);
      end
      ST_CHECK: bus.acc_start = 1'b1;
      ST_DONE:  bus.done      = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_pos        <= '0;
      r_vert       <= '0;
      r_tries      <= '0;
      r_success    <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_idx     <= '0;
            r_tries   <= '0;
            r_success <= 1'b0;
          end
        end
        ST_DRAW: begin
          if (w_fits) begin
            for (int i = 0; i < NUM_SHIPS; i++) begin
              if (r_idx == 3'(i)) begin
                r_pos[i]  <= w_pos;
                r_vert[i] <= w_cand_vert;
              end
            end
            // The index parks on the last ship so SHIP_LEN is never indexed past the fleet.
            if (!w_last_ship) r_idx <= r_idx + 3'd1;
          end
        end
        ST_CHECK: begin
          if (w_settle_last) begin
            r_settle_cnt <= '0;
            r_acc_valid  <= bus.acc_valid;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        ST_EVAL: begin
          r_tries <= w_tries_inc;
          if (r_acc_valid) begin
            r_success <= 1'b1;
          end else if (!w_limit_hit) begin
            r_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.success   = r_success;
  assign bus.tries     = r_tries;
  assign bus.ship_pos  = r_pos;
  assign bus.ship_vert = r_vert;

endmodule

// File: tb/tb_placement_scheduler.sv
// Scoreboard bench for placement_scheduler: a fleet-level reference model queues
// expected runs and load words; a monitor checks them as the DUT produces them.
`timescale 1ns/1ps
module tb_placement_scheduler;

  localparam int SETTLE = 2;
  localparam int MAXT   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  placement_scheduler_if bus();

  placement_scheduler #(
    .SETTLE_CYCLES (SETTLE),
    .MAX_TRIES     (MAXT),
    .DEFAULT_SEED  (16'hACE1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          success;
    int          tries;
    logic [34:0] pos;
    logic [4:0]  vert;
    int          latency;
    int          nwords;
    int          mode;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] word_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int runs_done = 0;
  int done_total = 0;
  int words_in_run = 0;
  bit sb_en = 0;
  int acc_mode = 0;
  int fail_n = 0;
  int check_num = 0;
  bit prev_start = 0;
  int acc_p[5];
  bit acc_v[5];
  int mon_p[5];
  bit mon_v[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int ship_len(input int i);
    case (i)
      0:       return 5;
      1:       return 4;
      2, 3:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit ship_fits(input int p, input bit v, input int len);
    if (p < 0 || p > 99) return 0;
    return v ? (p / 10 + len <= 10) : (p % 10 + len <= 10);
  endfunction

  // Legal fleet: every cell on the board, none in row 0, no cell shared.
  function automatic bit fleet_legal(input int p[5], input bit v[5]);
    bit occ[100];
    int c;
    for (int i = 0; i < 100; i++) occ[i] = 0;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < ship_len(s); k++) begin
        c = v[s] ? p[s] + 10 * k : p[s] + k;
        if (c < 10 || c > 99) return 0;
        if (occ[c]) return 0;
        occ[c] = 1;
      end
    end
    return 1;
  endfunction

  function automatic logic [31:0] mk_word(input int pa, input bit va, input int ta,
                                          input int pb, input bit vb, input int tb);
    logic [6:0] pa7, pb7;
    logic [2:0] ta3, tb3;
    pa7 = 7'(pa); pb7 = 7'(pb); ta3 = 3'(ta); tb3 = 3'(tb);
    return {pa7, va, ta3, pb7, vb, tb3, 10'b0};
  endfunction

  // Reference: replays draws one candidate per cycle and totals cycles per phase.
  task automatic model_run(input logic [15:0] seed, input int mode, input int fn, output exp_t e);
    logic [15:0] lf;
    int p[5];
    bit v[5];
    int row, col, len, tcount;
    bit ok, verdict;
    lf = (seed == 16'h0) ? 16'hACE1 : seed;
    e.success = 0; e.tries = 0; e.latency = 1; e.nwords = 0; e.mode = mode;
    e.pos = '0; e.vert = '0;
    tcount = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      for (int s = 0; s < 5; s++) begin
        len = ship_len(s);
        do begin
          row = int'(lf[3:0]);
          col = int'(lf[7:4]);
          v[s] = lf[8];
          lf = lfsr_step(lf);
          e.latency++;
          ok = (row < 10) && (col < 10) && (v[s] ? (row + len <= 10) : (col + len <= 10));
        end while (!ok);
        p[s] = row * 10 + col;
      end
      word_q.push_back(mk_word(p[0], v[0], 0, p[1], v[1], 1));
      word_q.push_back(mk_word(p[2], v[2], 2, p[3], v[3], 3));
      word_q.push_back(mk_word(p[4], v[4], 4, 0, 1'b0, 7));
      e.nwords += 3;
      e.latency += 3 + SETTLE + 1;
      tcount++;
      if (e.tries < 255) e.tries++;
      verdict = (mode == 0) ? (tcount > fn) : fleet_legal(p, v);
      if (verdict) begin
        e.success = 1;
        break;
      end
`ifdef PLACEMENT_RETRY_LIMIT_EN
      if (e.tries >= MAXT) break;
`endif
    end
    e.latency++;
    for (int s = 0; s < 5; s++) begin
      e.pos[7*s +: 7] = 7'(p[s]);
      e.vert[s] = v[s];
    end
  endtask

  // Accelerator stand-in: stub verdict by check count, or a real row-0/overlap check.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_num = 0;
      prev_start = 0;
      bus.acc_valid = 1'b0;
    end else begin
      if (bus.acc_update_ship) begin
        if (bus.acc_data[23:21] < 3'd5) begin
          acc_p[bus.acc_data[23:21]] = int'(bus.acc_data[31:25]);
          acc_v[bus.acc_data[23:21]] = bus.acc_data[24];
        end
        if (bus.acc_data[12:10] < 3'd5) begin
          acc_p[bus.acc_data[12:10]] = int'(bus.acc_data[20:14]);
          acc_v[bus.acc_data[12:10]] = bus.acc_data[13];
        end
      end
      if (bus.acc_start && !prev_start) check_num++;
      prev_start = bus.acc_start;
      if (bus.done) check_num = 0;
      bus.acc_valid = (acc_mode == 0) ? (check_num > fail_n) : fleet_legal(acc_p, acc_v);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) done_total++;
    if (rst_n && sb_en) begin
      if (bus.acc_update_ship) begin
        words_in_run++;
        check("upd_start_excl", {63'b0, bus.acc_start}, 64'd0);
        if (word_q.size() == 0) check("word_q_underflow", 64'd1, 64'd0);
        else check("load_word", {32'b0, bus.acc_data}, {32'b0, word_q.pop_front()});
      end
      if (bus.acc_start) check("acc_data_zero_in_check", {32'b0, bus.acc_data}, 64'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("success", {63'b0, bus.success}, {63'b0, e.success});
          check("tries", {56'b0, bus.tries}, 64'(e.tries));
          check("ship_pos", {29'b0, bus.ship_pos}, {29'b0, e.pos});
          check("ship_vert", {59'b0, bus.ship_vert}, {59'b0, e.vert});
          check("latency", 64'(cyc - issue_cyc + 1), 64'(e.latency));
          check("load_words", 64'(words_in_run), 64'(e.nwords));
          for (int s = 0; s < 5; s++) begin
            mon_p[s] = int'(bus.ship_pos[7*s +: 7]);
            mon_v[s] = bus.ship_vert[s];
            check("ship_in_bounds", {63'b0, ship_fits(mon_p[s], mon_v[s], ship_len(s))}, 64'd1);
          end
          if (e.mode == 1 && e.success)
            check("fleet_legal", {63'b0, fleet_legal(mon_p, mon_v)}, 64'd1);
          $display("run %0d: mode=%0d success=%0b tries=%0d latency=%0d pos=%h vert=%b",
                   runs_done, e.mode, bus.success, bus.tries, cyc - issue_cyc + 1,
                   bus.ship_pos, bus.ship_vert);
        end
        words_in_run = 0;
        runs_done++;
      end
    end
  end

  task automatic run_case(input logic [15:0] seed, input int mode, input int fn);
    exp_t e;
    int target;
    model_run(seed, mode, fn, e);
    exp_q.push_back(e);
    acc_mode = mode;
    fail_n = fn;
    target = runs_done + 1;
    @(negedge clk);
    issue_cyc = cyc;
    bus.seed = seed;
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 20000 && runs_done < target; i++) @(negedge clk);
    if (runs_done < target) begin
      check("run_timeout", 64'(runs_done), 64'(target));
      exp_q.delete();
      word_q.delete();
    end
    @(negedge clk);
  endtask

  // Starts a never-legal run, optionally confirms it keeps going, then resets in CHECK.
  task automatic abort_run(input bit check_long);
    int dones_before;
    sb_en = 0;
    acc_mode = 0;
    fail_n = 100000;
    dones_before = done_total;
    @(negedge clk);
    bus.seed = 16'($urandom);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    if (check_long) begin
      repeat (1000) @(negedge clk);
      check("unbounded_still_busy", {63'b0, bus.busy}, 64'd1);
      check("unbounded_no_done", 64'(done_total), 64'(dones_before));
    end
    for (int i = 0; i < 2000 && !bus.acc_start; i++) @(negedge clk);
    check("reach_check", {63'b0, bus.acc_start}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_acc_start", {63'b0, bus.acc_start}, 64'd0);
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_done", {63'b0, bus.done}, 64'd0);
    check("abort_tries", {56'b0, bus.tries}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done_pulse", 64'(done_total), 64'(dones_before));
    exp_q.delete();
    word_q.delete();
    words_in_run = 0;
    sb_en = 1;
  endtask

  initial begin
    logic [15:0] s;
    bus.req = 1'b0;
    bus.seed = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_success", {63'b0, bus.success}, 64'd0);
    check("rst_tries", {56'b0, bus.tries}, 64'd0);
    check("rst_ship_pos", {29'b0, bus.ship_pos}, 64'd0);
    check("rst_ship_vert", {59'b0, bus.ship_vert}, 64'd0);
    check("rst_acc_data", {32'b0, bus.acc_data}, 64'd0);
    check("rst_acc_update", {63'b0, bus.acc_update_ship}, 64'd0);
    check("rst_acc_start", {63'b0, bus.acc_start}, 64'd0);
    rst_n = 1'b1;
    sb_en = 1;

    run_case(16'h0001, 0, 0);
    run_case(16'($urandom), 0, 3);
    run_case(16'h0000, 0, 0);
    run_case(16'h0000, 0, 0);
    run_case(16'h1234, 0, 1);
    run_case(16'h1234, 0, 1);

`ifdef PLACEMENT_RETRY_LIMIT_EN
    run_case(16'hBEEF, 0, 100000);
    abort_run(1'b0);
`else
    abort_run(1'b1);
`endif
    run_case(16'h0001, 0, 0);

    for (int i = 0; i < 4; i++) run_case(16'($urandom), 1, 0);
    for (int i = 0; i < 6; i++) begin
      s = 16'($urandom);
      run_case(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("word_q_drained", 64'(word_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
